// File: rtl/s2p_line_assembler_pkg.sv
// rtl/s2p_line_assembler_pkg.sv - shared constants and state type for the line assembler
//   DEF_LINE_W / DEF_NUM_LINES : default line width and lines per word
//   WORD_W / CNT_W             : derived word width and line-counter width
//   state_t                    : COLLECT (accepting lines) / HOLD (final line parked)
package s2p_line_assembler_pkg;

  localparam int DEF_LINE_W    = 16;
  localparam int DEF_NUM_LINES = 16;
  localparam int WORD_W        = DEF_LINE_W * DEF_NUM_LINES;
  localparam int CNT_W         = $clog2(DEF_NUM_LINES);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/s2p_out_reg.sv
// rtl/s2p_out_reg.sv - output holding register with valid/ready handshake
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data and raise en
//   load_data  : word to capture
//   ready      : consumer accepts the held word this cycle
//   data, en   : held word and its valid flag
module s2p_out_reg
  import s2p_line_assembler_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         en
);

  // A load wins over a drain on the same edge, so back-to-back words
  // keep en high with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      en   <= 1'b0;
    end else if (load) begin
      data <= load_data;
      en   <= 1'b1;
    end else if (ready) begin
      en   <= 1'b0;
    end
  end

endmodule

// File: rtl/s2p_line_assembler.sv
// rtl/s2p_line_assembler.sv - reassembles NUM_LINES serial lines into one pixel word
//   clk, rst                        : clock, synchronous active-high reset
//   LINE_DATA/LINE_VALID/LINE_READY : incoming line stream
//   LINE_SOF                        : first-line marker (used only with S2P_SOF_CHECK_EN)
//   PIXEL_DATA_256/_EN/_READY       : assembled word stream
//   LINE_CNT                        : slot index of the next accepted line
//   SOF_ERR                         : sticky framing error (S2P_SOF_CHECK_EN, else 0)
// Build option: define S2P_SOF_CHECK_EN to enforce LINE_SOF framing.
module s2p_line_assembler
  import s2p_line_assembler_pkg::*;
#(
  parameter  int LINE_W    = DEF_LINE_W,
  parameter  int NUM_LINES = DEF_NUM_LINES,
  localparam int WORD_BITS = LINE_W * NUM_LINES,
  localparam int CNT_BITS  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LINE_W-1:0]    LINE_DATA,
  input  logic                 LINE_VALID,
  output logic                 LINE_READY,
  input  logic                 LINE_SOF,
  output logic [WORD_BITS-1:0] PIXEL_DATA_256,
  output logic                 PIXEL_DATA_EN,
  input  logic                 PIXEL_DATA_READY,
  output logic [CNT_BITS-1:0]  LINE_CNT,
  output logic                 SOF_ERR
);

  state_t               state;
  logic [CNT_BITS-1:0]  cnt;
  logic [WORD_BITS-1:0] asm_q;
  logic [WORD_BITS-1:0] merged;
  logic [WORD_BITS-1:0] load_data;
  logic [CNT_BITS-1:0]  slot;
  logic                 accept;
  logic                 outfree;
  logic                 sof_restart;
  logic                 sof_drop;
  logic                 write_en;
  logic                 final_line;
  logic                 load;

  assign LINE_READY = !rst && (state == COLLECT);
  assign accept     = LINE_VALID && LINE_READY;
  assign outfree    = !PIXEL_DATA_EN || PIXEL_DATA_READY;

`ifdef S2P_SOF_CHECK_EN
  // A misplaced SOF restarts the word at slot 0; a missing SOF at slot 0
  // means the line belongs to no word and is dropped.
  assign sof_restart = accept && LINE_SOF && (cnt != '0);
  assign sof_drop    = accept && !LINE_SOF && (cnt == '0);

  logic sof_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sof_err_q <= 1'b0;
    end else if (sof_restart || sof_drop) begin
      sof_err_q <= 1'b1;
    end
  end
  assign SOF_ERR = sof_err_q;
`else
  logic unused_sof;
  assign unused_sof  = LINE_SOF;
  assign sof_restart = 1'b0;
  assign sof_drop    = 1'b0;
  assign SOF_ERR     = 1'b0;
`endif

  assign slot       = sof_restart ? '0 : cnt;
  assign write_en   = accept && !sof_drop;
  assign final_line = write_en && (slot == CNT_BITS'(NUM_LINES - 1));

  // Assembly register with the incoming line dropped into its slot.
  always_comb begin
    merged = asm_q;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (slot == CNT_BITS'(i)) begin
        merged[i*LINE_W +: LINE_W] = LINE_DATA;
      end
    end
  end

  // In HOLD the final line already sits in asm_q.
  assign load_data = (state == HOLD) ? asm_q : merged;
  assign load      = (state == HOLD) ? outfree : (final_line && outfree);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= '0;
      asm_q <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (write_en) begin
            asm_q <= merged;
            cnt   <= slot + CNT_BITS'(1);
            if (final_line && !outfree) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (outfree) begin
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign LINE_CNT = cnt;

  s2p_out_reg #(
    .W(WORD_BITS)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(load_data),
    .ready    (PIXEL_DATA_READY),
    .data     (PIXEL_DATA_256),
    .en       (PIXEL_DATA_EN)
  );

endmodule

// File: tb/tb_s2p_line_assembler.sv
// tb/tb_s2p_line_assembler.sv - scoreboard bench for s2p_line_assembler
module tb_s2p_line_assembler;
  import s2p_line_assembler_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       LINE_DATA;
  logic              LINE_VALID;
  logic              LINE_READY;
  logic              LINE_SOF;
  logic [WORD_W-1:0] PIXEL_DATA_256;
  logic              PIXEL_DATA_EN;
  logic              PIXEL_DATA_READY;
  logic [CNT_W-1:0]  LINE_CNT;
  logic              SOF_ERR;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] m_asm = '0;
  int                m_cnt = 0;
  logic              m_err = 1'b0;
  logic [WORD_W-1:0] w1, w2;
  int                exp_cnt;
  logic              exp_err;

  always #5 clk = ~clk;

  s2p_line_assembler dut (
    .clk             (clk),
    .rst             (rst),
    .LINE_DATA       (LINE_DATA),
    .LINE_VALID      (LINE_VALID),
    .LINE_READY      (LINE_READY),
    .LINE_SOF        (LINE_SOF),
    .PIXEL_DATA_256  (PIXEL_DATA_256),
    .PIXEL_DATA_EN   (PIXEL_DATA_EN),
    .PIXEL_DATA_READY(PIXEL_DATA_READY),
    .LINE_CNT        (LINE_CNT),
    .SOF_ERR         (SOF_ERR)
  );

  task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_line_sof(input logic [15:0] d, input logic sof);
    int  budget = 0;
    bit  drop = 0;
    LINE_DATA  = d;
    LINE_SOF   = sof;
    LINE_VALID = 1'b1;
    @(negedge clk);
    while (!LINE_READY && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!LINE_READY) chk("line_ready_timeout", LINE_READY, 1);
    @(posedge clk);
    #1;
    LINE_VALID = 1'b0;
    LINE_SOF   = 1'b0;
`ifdef S2P_SOF_CHECK_EN
    if (sof && m_cnt != 0) begin
      m_err = 1'b1;
      m_cnt = 0;
    end else if (!sof && m_cnt == 0) begin
      m_err = 1'b1;
      drop  = 1;
    end
`endif
    if (!drop) begin
      m_asm[m_cnt*16 +: 16] = d;
      if (m_cnt == 15) begin
        exp_q.push_back(m_asm);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic send_line(input logic [15:0] d);
    send_line_sof(d, m_cnt == 0);
  endtask

  // Scoreboard: every word transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && PIXEL_DATA_EN && PIXEL_DATA_READY) begin
      chk("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("word", PIXEL_DATA_256, exp_q.pop_front());
    end
  end

  initial begin
    LINE_DATA = '0; LINE_VALID = 1'b0; LINE_SOF = 1'b0; PIXEL_DATA_READY = 1'b0;
    rst = 1'b1;
    cyc(2);
    chk("rst_line_ready", LINE_READY, 0);
    chk("rst_cnt", LINE_CNT, 0);
    chk("rst_en", PIXEL_DATA_EN, 0);
    chk("rst_data", PIXEL_DATA_256, 0);
    chk("rst_sof_err", SOF_ERR, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", LINE_READY, 1);

    // Back-to-back word, consumer ready
    PIXEL_DATA_READY = 1'b1;
    for (int k = 0; k < 15; k++) send_line(16'(k));
    chk("en_before_last", PIXEL_DATA_EN, 0);
    send_line(16'h000F);
    chk("en_latency", PIXEL_DATA_EN, 1);
    chk("word_lsb", PIXEL_DATA_256[15:0], 16'h0000);
    chk("word_msb", PIXEL_DATA_256[255:240], 16'h000F);
    chk("cnt_wrap", LINE_CNT, 0);
    cyc(1);
    chk("en_single_cycle", PIXEL_DATA_EN, 0);

    // Consumer stalled across two words
    PIXEL_DATA_READY = 1'b0;
    for (int k = 0; k < 32; k++) begin
      send_line(16'h1000 + 16'(k));
      if (k == 15) w1 = exp_q[$];
      if (k == 23) chk("held_stable", PIXEL_DATA_256, w1);
    end
    w2 = exp_q[$];
    chk("hold_ready", LINE_READY, 0);
    chk("hold_en", PIXEL_DATA_EN, 1);
    chk("hold_data", PIXEL_DATA_256, w1);
    PIXEL_DATA_READY = 1'b1;
    cyc(1);
    chk("word2_en", PIXEL_DATA_EN, 1);
    chk("word2_data", PIXEL_DATA_256, w2);
    chk("ready_back", LINE_READY, 1);
    cyc(1);
    chk("word2_drained", PIXEL_DATA_EN, 0);

    // Drain on the final-line cycle of the next word
    PIXEL_DATA_READY = 1'b0;
    for (int k = 0; k < 16; k++) send_line(16'h2000 + 16'(k));
    for (int k = 0; k < 15; k++) send_line(16'h3000 + 16'(k));
    chk("nobubble_en_held", PIXEL_DATA_EN, 1);
    PIXEL_DATA_READY = 1'b1;
    send_line(16'h300F);
    chk("nobubble_en", PIXEL_DATA_EN, 1);
    chk("nobubble_data", PIXEL_DATA_256, exp_q[$]);
    chk("nobubble_ready", LINE_READY, 1);
    cyc(1);
    chk("nobubble_drained", PIXEL_DATA_EN, 0);

    // Reset with a pending word and a partial word
    PIXEL_DATA_READY = 1'b0;
    for (int k = 0; k < 16; k++) send_line(16'h4000 + 16'(k));
    for (int k = 0; k < 7; k++) send_line(16'h5000 + 16'(k));
    chk("cnt_mid", LINE_CNT, 7);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_ready", LINE_READY, 0);
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    chk("rst_mid_cnt", LINE_CNT, 0);
    chk("rst_mid_en", PIXEL_DATA_EN, 0);
    PIXEL_DATA_READY = 1'b1;
    for (int k = 0; k < 16; k++) send_line(16'hA000 + 16'(k));
    chk("rst_word_lsb", PIXEL_DATA_256[15:0], 16'hA000);
    chk("rst_word_msb", PIXEL_DATA_256[255:240], 16'hA00F);
    cyc(1);

    // Random gaps on both sides
    for (int k = 0; k < 48; k++) begin
      PIXEL_DATA_READY = 1'($urandom_range(0, 1));
      send_line(16'(16'h6000 + k * 16'h0101));
      chk("cnt_track", LINE_CNT, m_cnt);
      cyc($urandom_range(0, 2));
    end
    PIXEL_DATA_READY = 1'b1;
    cyc(3);

    // Misplaced SOF at line 5
    for (int k = 0; k < 5; k++) send_line(16'hB000 + 16'(k));
    send_line_sof(16'hC005, 1'b1);
`ifdef S2P_SOF_CHECK_EN
    exp_cnt = 1;
    exp_err = 1'b1;
`else
    exp_cnt = 6;
    exp_err = 1'b0;
`endif
    chk("sof_cnt", LINE_CNT, exp_cnt);
    chk("sof_err", SOF_ERR, exp_err);
    while (m_cnt != 0) send_line(16'hD000 + 16'(m_cnt));
`ifdef S2P_SOF_CHECK_EN
    chk("sof_slot", PIXEL_DATA_256[15:0], 16'hC005);
`else
    chk("sof_slot", PIXEL_DATA_256[95:80], 16'hC005);
`endif
    cyc(3);
    chk("sof_err_final", SOF_ERR, m_err);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
